fifo_uart_tx: RTL

//  FIFO-drain serial transmitter; sits directly downstream of the 8-deep synchronous FIFO.

---
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-drain serial transmitter: pops one word at a time and sends it as
// start + LSB-first data + optional parity + stop bit(s).
module fifo_uart_tx #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_en,
    input  logic                 i_fifo_empty,
    input  logic [DATA_SIZE-1:0] i_fifo_data,
    output logic                 o_fifo_pop,
    output logic                 o_fifo_can_read,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_frame_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_SIZE) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_SIZE - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, POP, FETCH, START, DATA, PARITY, STOP} state_t;

    state_t               r_state, w_next;
    logic [DATA_SIZE-1:0] r_shift, w_shift_next;
    logic [BIT_W-1:0]     r_bit_cnt, w_bit_next;
    logic [BAUD_W-1:0]    r_baud, w_baud_next;
    logic                 r_parity, w_parity_next;
    logic                 r_tx, w_tx_next;
    logic                 r_pop, r_done;
    logic                 w_bit_end, w_can_start;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_can_start = i_tx_en && !i_fifo_empty;

    always_comb begin
        w_next        = r_state;
        w_shift_next  = r_shift;
        w_bit_next    = r_bit_cnt;
        w_parity_next = r_parity;
        case (r_state)
            IDLE:   if (w_can_start) w_next = POP;
            POP:    w_next = FETCH;
            FETCH: begin
                w_shift_next  = i_fifo_data;
                w_parity_next = (^i_fifo_data) ^ ODD_PAR;
                w_bit_next    = '0;
                w_next        = START;
            end
            START:  if (w_bit_end) w_next = DATA;
            DATA: if (w_bit_end) begin
                if (r_bit_cnt == DATA_LAST) begin
                    w_bit_next = '0;
                    w_next     = (PARITY_MODE != 0) ? PARITY : STOP;
                end else begin
                    w_bit_next   = r_bit_cnt + 1'b1;
                    w_shift_next = r_shift >> 1;
                end
            end
            PARITY: if (w_bit_end) w_next = STOP;
            // bit counter is reused to count stop bits
            STOP: if (w_bit_end) begin
                if (r_bit_cnt == STOP_LAST) begin
                    w_bit_next = '0;
                    w_next     = w_can_start ? POP : IDLE;
                end else begin
                    w_bit_next = r_bit_cnt + 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase

        w_baud_next = (w_next != r_state || w_bit_end) ? '0 : r_baud + 1'b1;

        // tx is registered, so it is decoded from the state being entered
        case (w_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_baud    <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_pop     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_next;
            r_baud    <= w_baud_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
            r_pop     <= (w_next == POP);
            r_done    <= (r_state == STOP) && w_bit_end && (r_bit_cnt == STOP_LAST);
        end
    end

    assign o_tx            = r_tx;
    assign o_fifo_pop      = r_pop;
    assign o_fifo_can_read = r_pop;
    assign o_frame_done    = r_done;
    assign o_busy          = (r_state != IDLE);

endmodule
